mc_ctrl_fsm: RTL

- Multi-cycle MIPS control unit: sequences the datapath through fetch/decode/execute/memory/writeback.
- Drives all 4-way select lines for the 32-bit and 5-bit 4-input muxes, the register/PC/IR/memory enables and the ALU operation.
- Sits between the instruction register fields and the datapath; stalls on a memory ready handshake.

---
 rtl/mc_ctrl_pkg.sv | 65 ++++++
 rtl/mc_alu_dec.sv | 39 +++
 rtl/mc_ctrl_fsm.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// instruction field constants, datapath select encodings and ALU op codes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // pc_sel
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  // reg_dst_sel
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  // wdata_sel
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;
  localparam logic [1:0] WD_LUI = 2'b11;

  // alu_b_sel
  localparam logic [1:0] B_RT   = 2'b00;
  localparam logic [1:0] B_SIMM = 2'b01;
  localparam logic [1:0] B_ZIMM = 2'b10;
  localparam logic [1:0] B_FOUR = 2'b11;

  // ALU operation codes (sized to alu_op width at the use site)
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_AND = 2;
  localparam int ALU_OR  = 3;
  localparam int ALU_SLT = 4;
  localparam int ALU_SLL = 5;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational instruction decoder: maps opcode/funct to the ALU operation
// used in the execute step and flags whether the instruction is supported.
module mc_alu_dec
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                legal
);

  // Decode ALU operation and legality; unknown encodings are illegal.
  always_comb begin
    alu_op = ALU_OP_W'(ALU_ADD);
    legal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin alu_op = ALU_OP_W'(ALU_ADD); legal = 1'b1; end
          FN_SUBU: begin alu_op = ALU_OP_W'(ALU_SUB); legal = 1'b1; end
          FN_AND:  begin alu_op = ALU_OP_W'(ALU_AND); legal = 1'b1; end
          FN_OR:   begin alu_op = ALU_OP_W'(ALU_OR);  legal = 1'b1; end
          FN_SLT:  begin alu_op = ALU_OP_W'(ALU_SLT); legal = 1'b1; end
          FN_SLL:  begin alu_op = ALU_OP_W'(ALU_SLL); legal = 1'b1; end
          FN_JR:   legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_BEQ:                   begin alu_op = ALU_OP_W'(ALU_SUB); legal = 1'b1; end
      OP_ORI:                   begin alu_op = ALU_OP_W'(ALU_OR);  legal = 1'b1; end
      OP_ADDIU, OP_LW, OP_SW:   legal = 1'b1;
      OP_LUI, OP_J, OP_JAL:     legal = 1'b1;
      default:                  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit. Steps the datapath through fetch, decode,
// execute, memory and writeback; selects are Moore (state/IR), enables that
// wait on memory or the zero flag are Mealy.
// Optional build macro MC_CTRL_PERF_EN adds cycle_cnt/instr_cnt counters.
//
// Handshake: in S_IF and S_MEM the request (mem_re or mem_we) is held high
// every cycle until mem_ready is seen high in the same cycle; that cycle
// completes the access and the FSM advances. mem_ready is ignored elsewhere.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_OP_W     = 4,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_we,
  output logic                ir_we,
  output logic                reg_we,
  output logic                mem_re,
  output logic                mem_we,
  output logic [1:0]          pc_sel,
  output logic [1:0]          reg_dst_sel,
  output logic [1:0]          wdata_sel,
  output logic [1:0]          alu_b_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                halted,
  output logic [2:0]          dbg_state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instr_cnt
`endif
);

  state_t                r_state;
  state_t                w_next;
  logic [ALU_OP_W-1:0]   w_alu_op;
  logic                  w_legal;
  logic                  w_is_jr;

  mc_alu_dec #(.ALU_OP_W(ALU_OP_W)) u_alu_dec (
    .opcode (opcode),
    .funct  (funct),
    .alu_op (w_alu_op),
    .legal  (w_legal)
  );

  assign w_is_jr   = (opcode == OP_RTYPE) && (funct == FN_JR);
  assign dbg_state = r_state;

  // State register; synchronous reset returns to fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IF;
    else        r_state <= w_next;
  end

  // Next state and all control outputs; reset forces every output idle.
  always_comb begin
    w_next      = r_state;
    pc_we       = 1'b0;
    ir_we       = 1'b0;
    reg_we      = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    pc_sel      = PC_PLUS4;
    reg_dst_sel = DST_RT;
    wdata_sel   = WD_ALU;
    alu_b_sel   = B_RT;
    alu_op      = ALU_OP_W'(ALU_ADD);
    halted      = 1'b0;

    case (r_state)
      S_IF: begin
        mem_re    = 1'b1;
        alu_b_sel = B_FOUR;
        pc_sel    = PC_PLUS4;
        if (mem_ready) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = S_ID;
        end
      end

      S_ID: begin
        if (!w_legal) begin
          w_next = ILLEGAL_HALT ? S_HALT : S_IF;
        end else if (opcode == OP_J) begin
          pc_sel = PC_JUMP;
          pc_we  = 1'b1;
          w_next = S_IF;
        end else if (opcode == OP_JAL) begin
          pc_sel      = PC_JUMP;
          pc_we       = 1'b1;
          reg_we      = 1'b1;
          reg_dst_sel = DST_RA;
          wdata_sel   = WD_PC4;
          w_next      = S_IF;
        end else if (w_is_jr) begin
          pc_sel = PC_RS;
          pc_we  = 1'b1;
          w_next = S_IF;
        end else begin
          w_next = S_EX;
        end
      end

      S_EX: begin
        alu_op = w_alu_op;
        case (opcode)
          OP_BEQ: begin
            alu_b_sel = B_RT;
            pc_sel    = PC_BRANCH;
            pc_we     = zero;
            w_next    = S_IF;
          end
          OP_LW, OP_SW: begin
            alu_b_sel = B_SIMM;
            w_next    = S_MEM;
          end
          OP_ADDIU: begin
            alu_b_sel = B_SIMM;
            w_next    = S_WB;
          end
          OP_ORI: begin
            alu_b_sel = B_ZIMM;
            w_next    = S_WB;
          end
          OP_LUI:  w_next = S_WB;
          default: begin
            alu_b_sel = B_RT;
            w_next    = S_WB;
          end
        endcase
      end

      S_MEM: begin
        if (opcode == OP_LW) mem_re = 1'b1;
        else                 mem_we = 1'b1;
        if (mem_ready) w_next = (opcode == OP_LW) ? S_WB : S_IF;
      end

      S_WB: begin
        reg_we = 1'b1;
        case (opcode)
          OP_RTYPE: reg_dst_sel = DST_RD;
          OP_LUI:   wdata_sel   = WD_LUI;
          OP_LW:    wdata_sel   = WD_MEM;
          default:  wdata_sel   = WD_ALU;
        endcase
        w_next = S_IF;
      end

      S_HALT: halted = 1'b1;

      default: w_next = S_IF;
    endcase

    if (!rst_n) begin
      pc_we       = 1'b0;
      ir_we       = 1'b0;
      reg_we      = 1'b0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      pc_sel      = PC_PLUS4;
      reg_dst_sel = DST_RT;
      wdata_sel   = WD_ALU;
      alu_b_sel   = B_RT;
      alu_op      = ALU_OP_W'(ALU_ADD);
      halted      = 1'b0;
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  // Cycle counter: every running cycle outside reset and halt.
  always_ff @(posedge clk) begin
    if (!rst_n)                 r_cycle_cnt <= '0;
    else if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 32'd1;
  end

  // Instruction counter: each return to fetch from a completing state.
  always_ff @(posedge clk) begin
    if (!rst_n)                                r_instr_cnt <= '0;
    else if (r_state != S_IF && w_next == S_IF) r_instr_cnt <= r_instr_cnt + 32'd1;
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule
